multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS sequencer: Moore FSM that drives the shared ALU, register file, PC and unified
//  memory port over 3-5 states per instruction, instead of a single-cycle decode.
//  Sits between the IR/opcode fields and the datapath muxes.
//  Memory accesses use a ready handshake, so memory latency is variable.
//  Supported: sll srl sra ori and or add addu addi sub subu slti slt lui lw sw beq bne j jal jr.
// PARAMETERS
//  CNT_W  32  width of retired-instruction counter icount (wraps modulo 2^CNT_W)
// PORTS
//  clk       in   1  rising-edge clock
//  rst_n     in   1  asynchronous active-low reset
//  OpCode    in   6  IR[31:26]; valid from the cycle after IRWr
//  funct     in   6  IR[5:0]
//  mem_ready in   1  memory completes the current MemRd/MemW this cycle
//  stall     in   1  freeze FSM and counter; all write strobes forced 0
//  IRWr      out  1  load IR
//  PCWr      out  1  unconditional PC write
//  PCWrCond  out  2  00 none, 01 beq (write if zero), 10 bne (write if !zero)
//  PCSrc     out  2  00 ALU result, 01 jump target {PC[31:28],imm26,00}, 10 reserved, 11 rs (jr)
//  IorD      out  1  memory address: 0 PC, 1 ALUOut
//  MemRd     out  1  memory read request
//  MemW      out  1  memory write request
//  RegW      out  1  register-file write
//  RegDst    out  2  00 rt, 01 rd, 10 $31
//  WBSel     out  2  00 ALUOut, 01 MDR, 10 PC (link)
//  AluSrcA   out  1  0 PC, 1 rs (or rt for shifts, with shift=1)
//  AluSrcB   out  2  00 rt, 01 const 4, 10 ext imm, 11 shamt
//  shift     out  1  shift-instruction operand routing
//  Aluctrl   out  5  `ALUOp_* code
//  ExtOp     out  2  `EXT_ZERO / `EXT_SIGNED / `EXT_HIGHPOS
//  illegal   out  1  one-cycle pulse in DECODE on an unsupported opcode/funct
//  instr_done out 1  one-cycle pulse in the last state of every legal instruction
//  icount    out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, icount=0, all outputs 0. IDLE->FETCH on the first clk after release.
//  Outputs decode the registered state (Moore), except IRWr/PCWr in FETCH, which are gated by mem_ready.
//  FETCH: MemRd=1, IorD=0, AluSrcA=0, AluSrcB=01, ADD. Hold until mem_ready; that cycle IRWr=PCWr=1, PCSrc=00 -> DECODE.
//  DECODE: ALU=PC+(signext imm<<2) for branch target; ExtOp=`EXT_SIGNED. Next state by class:
//   R-ALU/shift->EXEC_R; ori/addi/slti/lui->EXEC_I; lw/sw->MEM_ADDR; beq/bne->BRANCH; j->JUMP; jal->JAL; jr->JR.
//   Unsupported opcode/funct: illegal=1 -> FETCH; no writes, no icount increment.
//  EXEC_R: AluSrcA=1, AluSrcB=00 (11 and shift=1 for sll/srl/sra); Aluctrl per funct -> WB_R.
//   sub/subu both use `ALUOp_SUBU.
//  WB_R: RegW=1, RegDst=01, WBSel=00, instr_done -> FETCH.
//  EXEC_I: AluSrcB=10; ori `EXT_ZERO+OR, addi `EXT_SIGNED+ADD, slti `EXT_SIGNED+SLT, lui `EXT_HIGHPOS -> WB_I.
//  WB_I: RegW=1, RegDst=00, instr_done -> FETCH.
//  MEM_ADDR: rs+signext imm, ADD -> MEM_RD (lw) or MEM_WR (sw).
//  MEM_RD: MemRd=1, IorD=1; hold until mem_ready -> MEM_WB.
//  MEM_WB: RegW=1, RegDst=00, WBSel=01, instr_done -> FETCH.
//  MEM_WR: MemW=1, IorD=1; hold until mem_ready; that cycle instr_done -> FETCH.
//  BRANCH: rs-rt `ALUOp_SUBU; PCWrCond=01/10, PCSrc=00 (latched target), instr_done -> FETCH.
//  JUMP: PCWr=1, PCSrc=01. JR: PCWr=1, PCSrc=11.
//   JAL: RegW=1, RegDst=10, WBSel=10, PCWr=1, PCSrc=01 (link = already-incremented PC).
//   All three: instr_done -> FETCH.
//  Latency with zero wait: branch/jump 3 clk, R/I/sw 4, lw 5; each wait cycle adds 1.
//  stall=1: state, icount held; RegW/MemW/PCWr/IRWr/PCWrCond forced 0; MemRd held as is; mem_ready ignored.
//  icount += 1 on each instr_done when stall=0.
//  Reset mid-instruction aborts it; no partial writes after rst_n falls.
// STRUCTURE
//  State encodings, PCSrc/RegDst/WBSel/AluSrcB codes go in a shared define file next to ctrl_encode_def.v.
//  `ALUOp_*, `EXT_* and opcodes come from ctrl_encode_def.v / instruction_def.v.
//  Single module; the DECODE class lookup is a combinational function, not a sub-module.
// TESTING
//  Reset, mem_ready=1: addu sequence -> FETCH,DECODE,EXEC_R,WB_R; RegW in cycle 4; icount=1.
//  lw with mem_ready low 3 cycles in MEM_RD -> 8 cycles total; MemRd held; RegW+WBSel=01 only in MEM_WB.
//  beq OpCode=000100 -> PCWrCond=01 in cycle 3; bne -> 10; jal -> RegDst=10, WBSel=10, PCSrc=01, PCWr=1.
//  OpCode=111111 -> illegal pulse in DECODE, next state FETCH, icount unchanged, no write strobes.
//  stall=1 for 2 cycles in MEM_WR -> MemW=0, state held; then completes; rst_n=0 mid-lw -> IDLE, all outputs 0.
//  Preload icount to 2^CNT_W-1 (CNT_W=4), retire one instruction -> icount wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS sequencer: opcode/funct values,
// ALU operation codes, immediate-extension modes, datapath mux select codes,
// FSM state type and the DECODE instruction-class lookup.
package multicycle_ctrl_pkg;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes (IR[5:0])
    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    // ALU operation codes
    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADD  = 5'd1;
    localparam logic [4:0] ALUOP_ADDU = 5'd2;
    localparam logic [4:0] ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_AND  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;
    localparam logic [4:0] ALUOP_SLT  = 5'd6;
    localparam logic [4:0] ALUOP_SLL  = 5'd7;
    localparam logic [4:0] ALUOP_SRL  = 5'd8;
    localparam logic [4:0] ALUOP_SRA  = 5'd9;
    localparam logic [4:0] ALUOP_LUI  = 5'd10;  // pass operand B through

    // Immediate extension modes
    localparam logic [1:0] EXT_ZERO    = 2'd0;
    localparam logic [1:0] EXT_SIGNED  = 2'd1;
    localparam logic [1:0] EXT_HIGHPOS = 2'd2;

    // Datapath mux selects
    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;
    localparam logic [1:0] PCSRC_RS   = 2'b11;
    localparam logic [1:0] REGDST_RT  = 2'b00;
    localparam logic [1:0] REGDST_RD  = 2'b01;
    localparam logic [1:0] REGDST_RA  = 2'b10;
    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_MDR  = 2'b01;
    localparam logic [1:0] WBSEL_PC   = 2'b10;
    localparam logic [1:0] ALUB_RT    = 2'b00;
    localparam logic [1:0] ALUB_FOUR  = 2'b01;
    localparam logic [1:0] ALUB_IMM   = 2'b10;
    localparam logic [1:0] ALUB_SHAMT = 2'b11;
    localparam logic [1:0] PCWC_NONE  = 2'b00;
    localparam logic [1:0] PCWC_BEQ   = 2'b01;
    localparam logic [1:0] PCWC_BNE   = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR
    } state_t;

    typedef enum logic [3:0] {
        CL_ILLEGAL, CL_R, CL_I, CL_LW, CL_SW, CL_BR, CL_J, CL_JAL, CL_JR
    } iclass_t;

    // DECODE dispatch: which execution path an opcode/funct pair takes.
    function automatic iclass_t decode_class(input logic [5:0] op, input logic [5:0] fn);
        iclass_t c;
        c = CL_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_ADD, FN_ADDU, FN_SUB,
                    FN_SUBU, FN_AND, FN_OR, FN_SLT: c = CL_R;
                    FN_JR:                          c = CL_JR;
                    default:                        c = CL_ILLEGAL;
                endcase
            end
            OP_ORI, OP_ADDI, OP_SLTI, OP_LUI: c = CL_I;
            OP_LW:             c = CL_LW;
            OP_SW:             c = CL_SW;
            OP_BEQ, OP_BNE:    c = CL_BR;
            OP_J:              c = CL_J;
            OP_JAL:            c = CL_JAL;
            default:           c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] alu_r_op(input logic [5:0] fn);
        logic [4:0] a;
        case (fn)
            FN_SLL:          a = ALUOP_SLL;
            FN_SRL:          a = ALUOP_SRL;
            FN_SRA:          a = ALUOP_SRA;
            FN_ADD:          a = ALUOP_ADD;
            FN_ADDU:         a = ALUOP_ADDU;
            FN_SUB, FN_SUBU: a = ALUOP_SUBU;  // no overflow trap, so sub == subu
            FN_AND:          a = ALUOP_AND;
            FN_OR:           a = ALUOP_OR;
            FN_SLT:          a = ALUOP_SLT;
            default:         a = ALUOP_NOP;
        endcase
        return a;
    endfunction

    function automatic logic is_shift(input logic [5:0] fn);
        return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer. Moore FSM stepping each instruction through
// 3-5 states and driving the shared ALU, register file, PC and the unified
// memory port (ready handshake, variable latency).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   OpCode, funct       IR[31:26], IR[5:0]
//   mem_ready           memory completes current MemRd/MemW this cycle
//   stall               freeze FSM/counter, force write strobes low
//   IRWr PCWr PCWrCond PCSrc IorD MemRd MemW RegW RegDst WBSel
//   AluSrcA AluSrcB shift Aluctrl ExtOp  datapath controls
//   illegal             DECODE pulse on unsupported instruction
//   instr_done          last-state pulse of every legal instruction
//   icount              retired-instruction counter (wraps)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    input  logic             stall,
    output logic             IRWr,
    output logic             PCWr,
    output logic [1:0]       PCWrCond,
    output logic [1:0]       PCSrc,
    output logic             IorD,
    output logic             MemRd,
    output logic             MemW,
    output logic             RegW,
    output logic [1:0]       RegDst,
    output logic [1:0]       WBSel,
    output logic             AluSrcA,
    output logic [1:0]       AluSrcB,
    output logic             shift,
    output logic [4:0]       Aluctrl,
    output logic [1:0]       ExtOp,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] icount
);

    state_t           r_state;
    state_t           w_next;
    iclass_t          w_class;
    logic             w_ready;
    logic [CNT_W-1:0] r_icount;

    assign w_class = decode_class(OpCode, funct);
    // A handshake only counts when the sequencer is not frozen.
    assign w_ready = mem_ready & ~stall;
    assign icount  = r_icount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (!stall) begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_icount <= '0;
        end else if (instr_done && !stall) begin
            r_icount <= r_icount + CNT_W'(1);
        end
    end

    always_comb begin
        w_next     = r_state;
        IRWr       = 1'b0;
        PCWr       = 1'b0;
        PCWrCond   = PCWC_NONE;
        PCSrc      = PCSRC_ALU;
        IorD       = 1'b0;
        MemRd      = 1'b0;
        MemW       = 1'b0;
        RegW       = 1'b0;
        RegDst     = REGDST_RT;
        WBSel      = WBSEL_ALU;
        AluSrcA    = 1'b0;
        AluSrcB    = ALUB_RT;
        shift      = 1'b0;
        Aluctrl    = ALUOP_NOP;
        ExtOp      = EXT_ZERO;
        illegal    = 1'b0;
        instr_done = 1'b0;

        case (r_state)
            S_IDLE: w_next = S_FETCH;

            S_FETCH: begin
                // PC+4 computed while the instruction word is read
                MemRd   = 1'b1;
                AluSrcB = ALUB_FOUR;
                Aluctrl = ALUOP_ADD;
                if (w_ready) begin
                    IRWr   = 1'b1;
                    PCWr   = 1'b1;
                    w_next = S_DECODE;
                end
            end

            S_DECODE: begin
                // Speculative branch target PC + (sext(imm) << 2), latched in ALUOut
                AluSrcB = ALUB_IMM;
                ExtOp   = EXT_SIGNED;
                Aluctrl = ALUOP_ADD;
                case (w_class)
                    CL_R:    w_next = S_EXEC_R;
                    CL_I:    w_next = S_EXEC_I;
                    CL_LW,
                    CL_SW:   w_next = S_MEM_ADDR;
                    CL_BR:   w_next = S_BRANCH;
                    CL_J:    w_next = S_JUMP;
                    CL_JAL:  w_next = S_JAL;
                    CL_JR:   w_next = S_JR;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end

            S_EXEC_R: begin
                AluSrcA = 1'b1;
                Aluctrl = alu_r_op(funct);
                if (is_shift(funct)) begin
                    AluSrcB = ALUB_SHAMT;
                    shift   = 1'b1;
                end
                w_next = S_WB_R;
            end

            S_WB_R: begin
                RegW       = 1'b1;
                RegDst     = REGDST_RD;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_EXEC_I: begin
                AluSrcA = 1'b1;
                AluSrcB = ALUB_IMM;
                case (OpCode)
                    OP_ORI:  begin ExtOp = EXT_ZERO;    Aluctrl = ALUOP_OR;  end
                    OP_ADDI: begin ExtOp = EXT_SIGNED;  Aluctrl = ALUOP_ADD; end
                    OP_SLTI: begin ExtOp = EXT_SIGNED;  Aluctrl = ALUOP_SLT; end
                    OP_LUI:  begin ExtOp = EXT_HIGHPOS; Aluctrl = ALUOP_LUI; end
                    default: ;
                endcase
                w_next = S_WB_I;
            end

            S_WB_I: begin
                RegW       = 1'b1;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_MEM_ADDR: begin
                AluSrcA = 1'b1;
                AluSrcB = ALUB_IMM;
                ExtOp   = EXT_SIGNED;
                Aluctrl = ALUOP_ADD;
                w_next  = (OpCode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                MemRd = 1'b1;
                IorD  = 1'b1;
                if (w_ready) w_next = S_MEM_WB;
            end

            S_MEM_WB: begin
                RegW       = 1'b1;
                WBSel      = WBSEL_MDR;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_MEM_WR: begin
                MemW = 1'b1;
                IorD = 1'b1;
                // the store retires on the cycle memory accepts it
                if (w_ready) begin
                    instr_done = 1'b1;
                    w_next     = S_FETCH;
                end
            end

            S_BRANCH: begin
                AluSrcA    = 1'b1;
                Aluctrl    = ALUOP_SUBU;
                PCWrCond   = (OpCode == OP_BNE) ? PCWC_BNE : PCWC_BEQ;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_JUMP: begin
                PCWr       = 1'b1;
                PCSrc      = PCSRC_JUMP;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_JAL: begin
                // PC already holds PC+4 from FETCH, which is the link value
                RegW       = 1'b1;
                RegDst     = REGDST_RA;
                WBSel      = WBSEL_PC;
                PCWr       = 1'b1;
                PCSrc      = PCSRC_JUMP;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            S_JR: begin
                PCWr       = 1'b1;
                PCSrc      = PCSRC_RS;
                instr_done = 1'b1;
                w_next     = S_FETCH;
            end

            default: w_next = S_IDLE;
        endcase

        // Frozen cycles must not commit any architectural state.
        if (stall) begin
            IRWr     = 1'b0;
            PCWr     = 1'b0;
            PCWrCond = PCWC_NONE;
            RegW     = 1'b0;
            MemW     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed instruction sequences, a per-cycle
// model comparison and hand-computed spot checks.
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n, mem_ready, stall;
    logic [5:0]    OpCode, funct;
    logic          IRWr, PCWr, IorD, MemRd, MemW, RegW, AluSrcA, shift, illegal, instr_done;
    logic [1:0]    PCWrCond, PCSrc, RegDst, WBSel, AluSrcB, ExtOp;
    logic [4:0]    Aluctrl;
    logic [CW-1:0] icount;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct),
        .mem_ready(mem_ready), .stall(stall), .IRWr(IRWr), .PCWr(PCWr),
        .PCWrCond(PCWrCond), .PCSrc(PCSrc), .IorD(IorD), .MemRd(MemRd),
        .MemW(MemW), .RegW(RegW), .RegDst(RegDst), .WBSel(WBSel),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .shift(shift), .Aluctrl(Aluctrl),
        .ExtOp(ExtOp), .illegal(illegal), .instr_done(instr_done), .icount(icount)
    );

    typedef struct packed {
        logic IRWr; logic PCWr; logic [1:0] PCWrCond; logic [1:0] PCSrc;
        logic IorD; logic MemRd; logic MemW; logic RegW; logic [1:0] RegDst;
        logic [1:0] WBSel; logic AluSrcA; logic [1:0] AluSrcB; logic shift;
        logic [4:0] Aluctrl; logic [1:0] ExtOp; logic illegal; logic instr_done;
    } outs_t;

    outs_t obs;
    assign obs = {IRWr, PCWr, PCWrCond, PCSrc, IorD, MemRd, MemW, RegW, RegDst,
                  WBSel, AluSrcA, AluSrcB, shift, Aluctrl, ExtOp, illegal, instr_done};

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {P_FETCH, P_DECODE, P_ALU_R, P_WB_R, P_ALU_I, P_WB_I, P_ADDR,
                  P_LOAD, P_LOADWB, P_STORE, P_BR, P_J, P_JAL, P_JR, P_END} ph_t;

    // 0 illegal, 1 R-alu, 2 I-alu, 3 lw, 4 sw, 5 branch, 6 j, 7 jal, 8 jr
    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'b000000: begin
                if (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b100101, 6'b100100,
                               6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b101010}) return 1;
                if (fn == 6'b001000) return 8;
                return 0;
            end
            6'b001101, 6'b001000, 6'b001010, 6'b001111: return 2;
            6'b100011: return 3;
            6'b101011: return 4;
            6'b000100, 6'b000101: return 5;
            6'b000010: return 6;
            6'b000011: return 7;
            default:   return 0;
        endcase
    endfunction

    // The ordered list of phases an instruction walks through.
    function automatic ph_t phase_at(input logic [5:0] op, input logic [5:0] fn, input int idx);
        ph_t seq[6];
        for (int i = 0; i < 6; i++) seq[i] = P_END;
        seq[0] = P_FETCH;
        seq[1] = P_DECODE;
        case (kind(op, fn))
            1: begin seq[2] = P_ALU_R; seq[3] = P_WB_R; end
            2: begin seq[2] = P_ALU_I; seq[3] = P_WB_I; end
            3: begin seq[2] = P_ADDR;  seq[3] = P_LOAD; seq[4] = P_LOADWB; end
            4: begin seq[2] = P_ADDR;  seq[3] = P_STORE; end
            5: seq[2] = P_BR;
            6: seq[2] = P_J;
            7: seq[2] = P_JAL;
            8: seq[2] = P_JR;
            default: ;
        endcase
        return (idx >= 0 && idx < 6) ? seq[idx] : P_END;
    endfunction

    function automatic outs_t expect_out(input ph_t ph, input logic [5:0] op, input logic [5:0] fn,
                                         input logic mr, input logic st);
        outs_t e;
        logic go;
        e  = '0;
        go = !st;
        case (ph)
            P_FETCH:  begin e.MemRd = 1; e.AluSrcB = 2'b01; e.Aluctrl = ALUOP_ADD;
                            e.IRWr = mr && go; e.PCWr = mr && go; end
            P_DECODE: begin e.AluSrcB = 2'b10; e.ExtOp = EXT_SIGNED; e.Aluctrl = ALUOP_ADD;
                            e.illegal = (kind(op, fn) == 0); end
            P_ALU_R: begin
                e.AluSrcA = 1;
                case (fn)
                    6'b000000: e.Aluctrl = ALUOP_SLL;
                    6'b000010: e.Aluctrl = ALUOP_SRL;
                    6'b000011: e.Aluctrl = ALUOP_SRA;
                    6'b100101: e.Aluctrl = ALUOP_OR;
                    6'b100100: e.Aluctrl = ALUOP_AND;
                    6'b100000: e.Aluctrl = ALUOP_ADD;
                    6'b100001: e.Aluctrl = ALUOP_ADDU;
                    6'b101010: e.Aluctrl = ALUOP_SLT;
                    default:   e.Aluctrl = ALUOP_SUBU;
                endcase
                if (fn inside {6'b000000, 6'b000010, 6'b000011}) begin
                    e.AluSrcB = 2'b11; e.shift = 1;
                end
            end
            P_WB_R:   begin e.RegW = go; e.RegDst = 2'b01; e.instr_done = 1; end
            P_ALU_I: begin
                e.AluSrcA = 1; e.AluSrcB = 2'b10;
                case (op)
                    6'b001101: begin e.ExtOp = EXT_ZERO;    e.Aluctrl = ALUOP_OR;  end
                    6'b001000: begin e.ExtOp = EXT_SIGNED;  e.Aluctrl = ALUOP_ADD; end
                    6'b001010: begin e.ExtOp = EXT_SIGNED;  e.Aluctrl = ALUOP_SLT; end
                    default:   begin e.ExtOp = EXT_HIGHPOS; e.Aluctrl = ALUOP_LUI; end
                endcase
            end
            P_WB_I:   begin e.RegW = go; e.instr_done = 1; end
            P_ADDR:   begin e.AluSrcA = 1; e.AluSrcB = 2'b10; e.ExtOp = EXT_SIGNED;
                            e.Aluctrl = ALUOP_ADD; end
            P_LOAD:   begin e.MemRd = 1; e.IorD = 1; end
            P_LOADWB: begin e.RegW = go; e.WBSel = 2'b01; e.instr_done = 1; end
            P_STORE:  begin e.MemW = go; e.IorD = 1; e.instr_done = mr && go; end
            P_BR:     begin e.AluSrcA = 1; e.Aluctrl = ALUOP_SUBU; e.instr_done = 1;
                            e.PCWrCond = !go ? 2'b00 : (op == 6'b000100 ? 2'b01 : 2'b10); end
            P_J:      begin e.PCWr = go; e.PCSrc = 2'b01; e.instr_done = 1; end
            P_JR:     begin e.PCWr = go; e.PCSrc = 2'b11; e.instr_done = 1; end
            P_JAL:    begin e.RegW = go; e.RegDst = 2'b10; e.WBSel = 2'b10; e.PCWr = go;
                            e.PCSrc = 2'b01; e.instr_done = 1; end
            default: ;
        endcase
        return e;
    endfunction

    bit            started;
    int            step;
    logic [CW-1:0] mcount;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 0;
            step    <= 0;
            mcount  <= '0;
        end else if (!started) begin
            if (!stall) started <= 1;
        end else if (!stall) begin
            if (!(phase_at(OpCode, funct, step) inside {P_FETCH, P_LOAD, P_STORE}) || mem_ready) begin
                if (phase_at(OpCode, funct, step + 1) == P_END) begin
                    step <= 0;
                    if (kind(OpCode, funct) != 0) mcount <= mcount + 1'b1;
                end else begin
                    step <= step + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        outs_t e;
        e = started ? expect_out(phase_at(OpCode, funct, step), OpCode, funct, mem_ready, stall) : '0;
        chk("cycle_outputs", 32'(obs), 32'(e));
        chk("cycle_icount", 32'(icount), 32'(mcount));
    end

    // ---------------- stimulus ----------------
    outs_t hist [0:15];

    // One instruction of n cycles; mem_ready low in [rlo_a, rlo_a+rlo_n),
    // stall high in [st_a, st_a+st_n). Captures outputs of each cycle.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input int n,
                       input int rlo_a = 0, input int rlo_n = 0,
                       input int st_a = 0, input int st_n = 0);
        OpCode = op;
        funct  = fn;
        for (int c = 1; c <= n; c++) begin
            mem_ready = !(c >= rlo_a && c < rlo_a + rlo_n);
            stall     = (c >= st_a && c < st_a + st_n);
            #1;
            hist[c] = obs;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 0; mem_ready = 0; stall = 0; OpCode = '0; funct = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 32'(obs), 32'd0);
        chk("reset_icount", 32'(icount), 32'd0);
        rst_n = 1;
        @(posedge clk);
        #1;  // now in FETCH of the first instruction

        // addu: 4 cycles, register write in cycle 4
        run(6'b000000, 6'b100001, 4);
        chk("addu_c1_irwr", 32'(hist[1].IRWr), 1);
        chk("addu_c3_regw", 32'(hist[3].RegW), 0);
        chk("addu_c4_regw", 32'(hist[4].RegW), 1);
        chk("addu_c4_regdst", 32'(hist[4].RegDst), 32'b01);
        chk("addu_icount", 32'(icount), 1);

        // lw with 3 wait cycles in the read: 8 cycles
        run(6'b100011, 6'b000000, 8, 4, 3);
        chk("lw_memrd_held", 32'(hist[4].MemRd & hist[5].MemRd & hist[6].MemRd & hist[7].MemRd), 1);
        chk("lw_c7_regw", 32'(hist[7].RegW), 0);
        chk("lw_c8_regw_wbsel", 32'({hist[8].RegW, hist[8].WBSel}), 32'b101);
        chk("lw_icount", 32'(icount), 2);

        run(6'b000100, 6'b000000, 3);
        chk("beq_c3_pcwrcond", 32'(hist[3].PCWrCond), 32'b01);
        chk("beq_c3_done", 32'(hist[3].instr_done), 1);
        run(6'b000101, 6'b000000, 3);
        chk("bne_c3_pcwrcond", 32'(hist[3].PCWrCond), 32'b10);
        run(6'b000011, 6'b000000, 3);
        chk("jal_c3", 32'({hist[3].RegDst, hist[3].WBSel, hist[3].PCSrc, hist[3].PCWr}), 32'b1010011);
        chk("jal_icount", 32'(icount), 5);

        // unsupported opcode: 2 cycles, no retire
        run(6'b111111, 6'b000000, 2);
        chk("ill_c1", 32'(hist[1].illegal), 0);
        chk("ill_c2", 32'(hist[2].illegal), 1);
        chk("ill_no_writes", 32'({hist[2].RegW, hist[2].MemW, hist[2].PCWr,
                                  hist[2].PCWrCond, hist[2].IRWr}), 0);
        chk("ill_icount", 32'(icount), 5);
        run(6'b001101, 6'b000000, 4);  // ori right after: must start in FETCH
        chk("ori_c1_fetch", 32'({hist[1].MemRd, hist[1].IRWr}), 32'b11);
        chk("ori_icount", 32'(icount), 6);

        // sw stalled for 2 cycles in the write phase
        run(6'b101011, 6'b000000, 6, 0, 0, 4, 2);
        chk("sw_stall_memw", 32'({hist[4].MemW, hist[5].MemW}), 0);
        chk("sw_stall_done", 32'(hist[4].instr_done), 0);
        chk("sw_c6", 32'({hist[6].MemW, hist[6].IorD, hist[6].instr_done}), 32'b111);
        chk("sw_icount", 32'(icount), 7);

        // eight more take icount to 15, the ninth wraps it
        run(6'b000000, 6'b000000, 4);  // sll
        run(6'b000000, 6'b000011, 4);  // sra
        run(6'b000000, 6'b100010, 4);  // sub
        run(6'b000000, 6'b100100, 4);  // and
        run(6'b000000, 6'b101010, 4);  // slt
        run(6'b001000, 6'b000000, 4);  // addi
        run(6'b001010, 6'b000000, 4);  // slti
        run(6'b001111, 6'b000000, 4);  // lui
        chk("icount_max", 32'(icount), 15);
        run(6'b000000, 6'b001000, 3);  // jr
        chk("jr_c3_pcsrc", 32'(hist[3].PCSrc), 32'b11);
        chk("icount_wrap", 32'(icount), 0);

        run(6'b000010, 6'b000000, 3);  // j
        chk("j_icount", 32'(icount), 1);

        // reset while lw is waiting in the read phase
        run(6'b100011, 6'b000000, 4, 4, 3);
        chk("lw_abort_memrd", 32'(hist[4].MemRd), 1);
        mem_ready = 0;
        rst_n = 0;
        #1;
        chk("abort_outputs", 32'(obs), 32'd0);
        chk("abort_icount", 32'(icount), 0);
        repeat (2) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
